// File: rtl/led_pkg.sv
// ============================================================================
// Module  : led_pkg
// Brief   : Shared types and default widths for the LED blink array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_BURST = 2'b11
    } led_mode_t;

    typedef enum logic {
        BURST_IDLE = 1'b0,
        BURST_RUN  = 1'b1
    } burst_state_t;

    localparam int c_hp_w_default = 8;
    localparam int c_bl_w_default = 8;

endpackage

`default_nettype wire

// File: rtl/led_blink_chan.sv
// ============================================================================
// Module  : led_blink_chan
// Brief   : One LED channel: tick counter, burst FSM, led/busy/done registers.
//           LED_ACTIVE_LOW_EN inverts the led pin (busy/done unaffected).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blink_chan
    import led_pkg::*;
#(
    parameter int HP_W = c_hp_w_default,
    parameter int BL_W = c_bl_w_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  led_mode_t       mode,
    input  logic [HP_W-1:0] half_per,
    input  logic [BL_W-1:0] burst_len,
    input  logic            start,
    output logic            led,
    output logic            busy,
    output logic            done
);

    led_mode_t    r_mode;
    burst_state_t r_state;
    logic [HP_W-1:0] r_cnt;
    logic [BL_W-1:0] r_pulses;
    logic         r_led;
    logic         r_busy;
    logic         r_done;

    burst_state_t w_state;
    logic [HP_W-1:0] w_cnt;
    logic [BL_W-1:0] w_pulses;
    logic         w_led;
    logic         w_busy;
    logic         w_done;
    logic [HP_W-1:0] w_eff;
    logic         w_wrap;

    // A zero half-period behaves as one; >= lets a shrunken period wrap at once.
    assign w_eff  = (half_per == '0) ? HP_W'(1) : half_per;
    assign w_wrap = (r_cnt >= (w_eff - HP_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode   <= LED_OFF;
            r_state  <= BURST_IDLE;
            r_cnt    <= '0;
            r_pulses <= '0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_mode   <= mode;
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_pulses <= w_pulses;
            r_led    <= w_led;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_pulses = r_pulses;
        w_led    = r_led;
        w_busy   = r_busy;
        w_done   = 1'b0;
        if (mode != r_mode) begin
            // Mode change edge: restart cleanly, aborting any burst without done.
            w_state  = BURST_IDLE;
            w_cnt    = '0;
            w_pulses = '0;
            w_led    = (mode == LED_ON);
            w_busy   = 1'b0;
        end else begin
            case (mode)
                LED_OFF, LED_ON: begin
                    w_state = BURST_IDLE;
                    w_cnt   = '0;
                    w_led   = (mode == LED_ON);
                    w_busy  = 1'b0;
                end
                LED_BLINK: begin
                    if (tick) begin
                        if (w_wrap) begin
                            w_led = ~r_led;
                            w_cnt = '0;
                        end else begin
                            w_cnt = r_cnt + HP_W'(1);
                        end
                    end
                end
                LED_BURST: begin
                    case (r_state)
                        BURST_IDLE: begin
                            w_led  = 1'b0;
                            w_busy = 1'b0;
                            w_cnt  = '0;
                            if (start) begin
                                if (burst_len != '0) begin
                                    w_state  = BURST_RUN;
                                    w_led    = 1'b1;
                                    w_busy   = 1'b1;
                                    w_pulses = burst_len;
                                end else begin
                                    w_done = 1'b1;
                                end
                            end
                        end
                        BURST_RUN: begin
                            if (tick) begin
                                if (w_wrap) begin
                                    w_cnt = '0;
                                    if (r_led) begin
                                        w_led    = 1'b0;
                                        w_pulses = r_pulses - BL_W'(1);
                                        if (r_pulses == BL_W'(1)) begin
                                            w_state = BURST_IDLE;
                                            w_busy  = 1'b0;
                                            w_done  = 1'b1;
                                        end
                                    end else begin
                                        w_led = 1'b1;
                                    end
                                end else begin
                                    w_cnt = r_cnt + HP_W'(1);
                                end
                            end
                        end
                        default: w_state = BURST_IDLE;
                    endcase
                end
                default: w_state = BURST_IDLE;
            endcase
        end
    end

    always_comb begin
`ifdef LED_ACTIVE_LOW_EN
        led  = ~r_led;
`else
        led  = r_led;
`endif
        busy = r_busy;
        done = r_done;
    end

endmodule

`default_nettype wire

// File: rtl/led_blink_array.sv
// ============================================================================
// Module  : led_blink_array
// Brief   : NUM_LEDS independent blink/burst channels sharing one tick enable.
//           LED_ACTIVE_LOW_EN (in led_blink_chan) makes the led pins active-low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_blink_array
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int HP_W     = c_hp_w_default,
    parameter int BL_W     = c_bl_w_default
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [2*NUM_LEDS-1:0]    mode,
    input  logic [HP_W*NUM_LEDS-1:0] half_per,
    input  logic [BL_W*NUM_LEDS-1:0] burst_len,
    input  logic [NUM_LEDS-1:0]      start,
    output logic [NUM_LEDS-1:0]      led,
    output logic [NUM_LEDS-1:0]      busy,
    output logic [NUM_LEDS-1:0]      done
);

    generate
        for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
            led_blink_chan #(
                .HP_W (HP_W),
                .BL_W (BL_W)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .tick      (tick),
                .mode      (led_mode_t'(mode[2*i +: 2])),
                .half_per  (half_per[HP_W*i +: HP_W]),
                .burst_len (burst_len[BL_W*i +: BL_W]),
                .start     (start[i]),
                .led       (led[i]),
                .busy      (busy[i]),
                .done      (done[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire
